aes_cbc_dec_ctrl: RTL and testbench

AES_CBC_DEC_CTRL -- requirements
Module: aes_cbc_dec_ctrl

---
 rtl/aes_cbc_dec_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_cbc_dec_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_dec_ctrl.sv
// CBC-mode decrypt sequencer around an external AES decrypt core.
// One block in flight: accept ciphertext, run the core, XOR with the chain value, emit plaintext.
module aes_cbc_dec_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [1:0]   cfg_mode,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
  output logic         cfg_ready,
  input  logic         ct_valid,
  input  logic [127:0] ct_data,
  input  logic         ct_last,
  output logic         ct_ready,
  output logic         pt_valid,
  output logic [127:0] pt_data,
  output logic         pt_last,
  input  logic         pt_ready,
  output logic         core_start,
  output logic [1:0]   core_mode,
  output logic [255:0] core_key,
  output logic [127:0] core_ciphertext,
  input  logic [127:0] core_plaintext,
  input  logic         core_done,
  output logic         busy,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWaitCt, StStart, StRun, StOut} state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q;
  logic [255:0]   key_q;
  logic [127:0]   chain_q;
  logic [127:0]   ct_q;
  logic           last_q;
  logic [127:0]   pt_data_q;
  logic           pt_last_q;
  logic           err_q;
  logic [15:0]    blk_cnt_q;
  logic [TW-1:0]  timer_q;

  logic cfg_legal;
  logic timeout_hit;

  assign cfg_legal   = cfg_valid && (cfg_mode != 2'b11);
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cfg_legal) state_d = StWaitCt;
      StWaitCt: if (ct_valid) state_d = StStart;
      StStart:  state_d = StRun;
      StRun: begin
        if (core_done)        state_d = StOut;
        else if (timeout_hit) state_d = StIdle;
      end
      StOut:    if (pt_ready) state_d = pt_last_q ? StIdle : StWaitCt;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready  = 1'b0;
    ct_ready   = 1'b0;
    core_start = 1'b0;
    pt_valid   = 1'b0;
    unique case (state_q)
      StIdle:   cfg_ready  = 1'b1;
      StWaitCt: ct_ready   = 1'b1;
      StStart:  core_start = 1'b1;
      StOut:    pt_valid   = 1'b1;
      default:  ;
    endcase
  end

  // Session, block and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 2'b00;
      key_q     <= '0;
      chain_q   <= '0;
      ct_q      <= '0;
      last_q    <= 1'b0;
      pt_data_q <= '0;
      pt_last_q <= 1'b0;
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_legal) begin
            mode_q    <= cfg_mode;
            key_q     <= cfg_key;
            chain_q   <= cfg_iv;
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
          end else if (cfg_valid) begin
            err_q <= 1'b1;
          end
        end
        StWaitCt: begin
          if (ct_valid) begin
            ct_q   <= ct_data;
            last_q <= ct_last;
          end
        end
        StStart: timer_q <= '0;
        StRun: begin
          if (core_done) begin
            pt_data_q <= core_plaintext ^ chain_q;
            pt_last_q <= last_q;
            chain_q   <= ct_q;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StOut: begin
          if (pt_ready && (blk_cnt_q != 16'hFFFF)) blk_cnt_q <= blk_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state_q != StIdle);
  assign err             = err_q;
  assign blk_cnt         = blk_cnt_q;
  assign pt_data         = pt_data_q;
  assign pt_last         = pt_last_q;
  assign core_mode       = mode_q;
  assign core_key        = key_q;
  assign core_ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Scoreboard bench for aes_cbc_dec_ctrl with a behavioural AES core model
// (known-answer lookup, fixed-value stub, or never-done).
module tb_aes_cbc_dec_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic [1:0]   cfg_mode;
  logic [255:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         cfg_ready;
  logic         ct_valid;
  logic [127:0] ct_data;
  logic         ct_last;
  logic         ct_ready;
  logic         pt_valid;
  logic [127:0] pt_data;
  logic         pt_last;
  logic         pt_ready;
  logic         core_start;
  logic [1:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_ciphertext;
  logic [127:0] core_plaintext;
  logic         core_done;
  logic         busy;
  logic         err;
  logic [15:0]  blk_cnt;

  localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] STUB_P = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] BLK_A  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] BLK_B  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int pv_cnt = 0;
  int core_kind = 0;  // 0 known-answer core, 1 fixed-P stub, 2 never done
  logic [128:0] sb[$];

  aes_cbc_dec_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_ready(cfg_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_last(ct_last), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pt_ready),
    .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .core_plaintext(core_plaintext), .core_done(core_done),
    .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] core_fn(input logic [1:0] m, input logic [255:0] k,
                                           input logic [127:0] c);
    if (core_kind == 1) return STUB_P;
    if (m == 2'b00 && k == K128 && c == C128) return PT;
    if (m == 2'b01 && k == K192 && c == C192) return PT;
    if (m == 2'b10 && k == K256 && c == C256) return PT;
    return 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  endfunction

  // Core model: latency 3 cycles after the start pulse
  initial begin
    logic [127:0] res;
    core_done = 1'b0;
    core_plaintext = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        start_cnt++;
        if (core_kind != 2) begin
          res = core_fn(core_mode, core_key, core_ciphertext);
          repeat (3) @(posedge clk);
          #1 core_done = 1'b1;
          core_plaintext = res;
          @(posedge clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pop and compare on every plaintext handshake
  initial begin
    logic [128:0] e;
    forever begin
      @(negedge clk);
      if (pt_valid) pv_cnt++;
      if (pt_valid && pt_ready && !rst) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pt: got %h expected none", pt_data);
        end else begin
          e = sb.pop_front();
          chk("pt_data", {128'h0, pt_data}, {128'h0, e[128:1]});
          chk("pt_last", {255'h0, pt_last}, {255'h0, e[0]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic load_cfg(input logic [1:0] m, input logic [255:0] k, input logic [127:0] iv);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = m; cfg_key = k; cfg_iv = iv;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_ct(input logic [127:0] d, input logic l);
    int n;
    @(posedge clk); #1;
    ct_valid = 1'b1; ct_data = d; ct_last = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ct_ready && n < 100);
    if (!ct_ready) chk("ct_ready_wait", 0, 1);
    @(posedge clk); #1;
    ct_valid = 1'b0;
    @(negedge clk);
    chk("start_latency", {255'h0, core_start}, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, {255'h0, cfg_ready}, 1);
  endtask

  initial begin
    int s0, p0, n;
    logic [127:0] held;
    rst = 1'b1; cfg_valid = 0; cfg_mode = 0; cfg_key = '0; cfg_iv = '0;
    ct_valid = 0; ct_data = '0; ct_last = 0; pt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", {255'h0, cfg_ready}, 1);
    chk("rst_busy", {255'h0, busy}, 0);
    chk("rst_pt_valid", {255'h0, pt_valid}, 0);
    chk("rst_ct_ready", {255'h0, ct_ready}, 0);
    chk("rst_err", {255'h0, err}, 0);
    chk("rst_blk_cnt", {240'h0, blk_cnt}, 0);
    chk("rst_core_start", {255'h0, core_start}, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_pt_data", {128'h0, pt_data}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Known-answer vectors, three key sizes
    core_kind = 0;
    load_cfg(2'b00, K128, '0);
    chk("kat128_key", core_key, K128);
    sb.push_back({PT, 1'b1});
    send_ct(C128, 1'b1);
    chk("kat128_ct_hold", {128'h0, core_ciphertext}, {128'h0, C128});
    wait_idle("kat128_idle");
    chk("kat128_blk_cnt", {240'h0, blk_cnt}, 1);
    load_cfg(2'b10, K256, '0);
    sb.push_back({PT, 1'b1});
    send_ct(C256, 1'b1);
    wait_idle("kat256_idle");
    load_cfg(2'b01, K192, '0);
    sb.push_back({PT, 1'b1});
    send_ct(C192, 1'b1);
    wait_idle("kat192_idle");
    chk("kat192_blk_cnt", {240'h0, blk_cnt}, 1);

    // Two-block CBC chain with stub core; mid-session cfg ignored
    core_kind = 1;
    load_cfg(2'b00, K128, 128'h1);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_key = '1; cfg_iv = '1;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("midsess_mode", {254'h0, core_mode}, 0);
    chk("midsess_key", core_key, K128);
    s0 = start_cnt;
    sb.push_back({STUB_P ^ 128'h1, 1'b0});
    sb.push_back({STUB_P ^ BLK_A, 1'b1});
    send_ct(BLK_A, 1'b0);
    send_ct(BLK_B, 1'b1);
    wait_idle("chain_idle");
    chk("chain_blk_cnt", {240'h0, blk_cnt}, 2);
    chk("chain_starts", start_cnt - s0, 2);

    // Backpressure on the plaintext side
    load_cfg(2'b00, K128, '0);
    pt_ready = 1'b0;
    s0 = start_cnt;
    sb.push_back({STUB_P, 1'b1});
    send_ct(BLK_B, 1'b1);
    n = 0;
    while (!pt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_pt_valid", {255'h0, pt_valid}, 1);
    held = pt_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_pt_stable", {128'h0, pt_data}, {128'h0, held});
      chk("stall_ct_ready", {255'h0, ct_ready}, 0);
    end
    chk("stall_starts", start_cnt - s0, 1);
    @(posedge clk); #1 pt_ready = 1'b1;
    wait_idle("stall_idle");

    // Illegal mode
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = 2'b11;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("illegal_err", {255'h0, err}, 1);
    chk("illegal_cfg_ready", {255'h0, cfg_ready}, 1);
    chk("illegal_busy", {255'h0, busy}, 0);

    // Timeout with a core that never finishes
    core_kind = 2;
    load_cfg(2'b00, K128, '0);
    @(negedge clk);
    chk("legal_clears_err", {255'h0, err}, 0);
    p0 = pv_cnt;
    send_ct(BLK_A, 1'b1);
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 9);
    chk("timeout_err", {255'h0, err}, 1);
    chk("timeout_no_pt", pv_cnt - p0, 0);

    // Reset during RUN followed by a stray core_done
    core_kind = 1;
    load_cfg(2'b00, K128, '0);
    p0 = pv_cnt;
    send_ct(BLK_A, 1'b1);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstrun_busy", {255'h0, busy}, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstrun_cfg_ready", {255'h0, cfg_ready}, 1);
    chk("rstrun_pt_data", {128'h0, pt_data}, 0);
    chk("rstrun_core_key", core_key, 0);
    chk("rstrun_ciphertext", {128'h0, core_ciphertext}, 0);
    chk("rstrun_blk_cnt", {240'h0, blk_cnt}, 0);
    repeat (5) @(negedge clk);
    chk("rstrun_still_idle", {255'h0, busy}, 0);
    chk("rstrun_no_pt", pv_cnt - p0, 0);
    core_kind = 0;
    load_cfg(2'b00, K128, '0);
    sb.push_back({PT, 1'b1});
    send_ct(C128, 1'b1);
    wait_idle("post_rst_idle");
    chk("post_rst_blk_cnt", {240'h0, blk_cnt}, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
